stream_pack_arbiter: RTL
========================

STREAM_PACK_ARBITER -- requirements
Module: stream_pack_arbiter

Interface
REQ-001 Parameter N_REQ, default 2: number of requesters sharing the 32b-to-64b packer.
REQ-002 Parameter ACT_DATA_WIDTH, default 8: lane width; one word is 4 lanes (32b).
REQ-003 Parameter LEN_WIDTH, default 16: width of the burst-length field, counted in 32b words.
REQ-004 Clocking and reset: one clock; reset is asynchronous and active-low (ports clk, reset).
REQ-005 clk  in  1  clock.
REQ-006 reset  in  1  asynchronous active-low reset.
REQ-007 req  in  N_REQ  per-requester burst request, level.
REQ-008 req_len  in  N_REQ*LEN_WIDTH  per-requester burst length in words; sampled at grant.
REQ-009 req_valid  in  N_REQ  per-requester word valid.
REQ-010 req_word  in  N_REQ*4*ACT_DATA_WIDTH  per-requester data word.
REQ-011 req_addr  in  N_REQ*32  per-requester word address.
REQ-012 gnt  out  N_REQ  one-hot grant, registered.
REQ-013 req_ready  out  N_REQ  word accepted when req_valid & req_ready.
REQ-014 done  out  N_REQ  one-cycle burst-complete pulse.
REQ-015 pack_en  out  1  drives the packer input_en.
REQ-016 pack_word  out  4*ACT_DATA_WIDTH  drives the packer input_word.
REQ-017 pack_addr  out  32  drives the packer input_addr.
REQ-018 busy  out  1  high in any state other than IDLE.

Function
REQ-019 FSM states: IDLE, XFER, PAD, DONE; state transitions occur on the clk rising edge.
REQ-020 IDLE: if any req bit is high, grant one requester by round-robin starting at rr_ptr; latch req_len into word counter cnt; go to XFER, or to DONE if the latched length is 0.
REQ-021 The grant is registered: gnt is asserted the cycle after req is sampled and held constant until DONE completes.
REQ-022 XFER: req_ready[g]=1 for the granted g only; pack_en = req_valid[g] combinationally; pack_word/pack_addr = req_word[g]/req_addr[g] (zero-latency pass-through).
REQ-023 Each accepted word decrements cnt and toggles the parity bit; when the last word is accepted (cnt==1), go to PAD if parity was 0 before the toggle (odd count), else to DONE.
REQ-024 PAD: a single cycle with pack_en=1, pack_word=0, pack_addr = last accepted address + 4, and req_ready=0; this keeps the packer pair-aligned. Then go to DONE.
REQ-025 DONE: done[g]=1 for one cycle, gnt cleared, rr_ptr = g+1 mod N_REQ, parity=0; go to IDLE.
REQ-026 A requester dropping req mid-burst is ignored; the burst completes after exactly the latched length.
REQ-027 Gaps in req_valid during XFER stall the burst with no timeout; pack_en=0 during gaps.
REQ-028 pack_en is never asserted in IDLE or DONE; at most one requester sees req_ready per cycle.
REQ-029 Simultaneous requests are resolved by round-robin; with a single active requester, back-to-back bursts incur two idle cycles (DONE, IDLE).

Reset
REQ-030 Reset value: state=IDLE, cnt=0, parity=0, rr_ptr=0, gnt=0, req_ready=0, done=0, pack_en=0, pack_word=0, pack_addr=0, busy=0.
REQ-031 Reset asserted mid-burst aborts the burst immediately with no PAD and no done pulse; the packer must be reset by the same reset.

Structure
REQ-032 Shared package stream_pkg shall hold ACT_DATA_WIDTH, N_DIM_ARRAY, and the FSM state typedef.
REQ-033 The round-robin picker shall be a sub-module, rr_pick (inputs req, rr_ptr; output one-hot pick), and purely combinational.

Verification
REQ-034 Test 1: req[0] with len=4 and continuous valid, words 0x11111111 to 0x44444444 -> four pack_en pulses, no PAD, done[0] pulses once, packer emits 2 output_en.
REQ-035 Test 2: req[1] with len=3 and req_addr 0x100, 0x104, 0x108 -> three data pulses plus a PAD cycle (pack_word=0, pack_addr=0x10C), then done[1].
REQ-036 Test 3: req=2'b11 held with len=2 each -> grants alternate 0,1,0,1; gnt never changes within a burst.
REQ-037 Test 4: req[0] with len=0 -> gnt[0] for one cycle, done[0] pulses, no pack_en.
REQ-038 Test 5: len=6 with valid toggling every other cycle, and reset asserted after 3 words -> all outputs return to reset values asynchronously, with no done pulse; the next burst starts at rr_ptr=0 with parity 0.

Source files
------------

// File: rtl/stream_pkg.sv
// Shared parameters, FSM state encoding and a pointer-width helper
// for the stream pack arbiter.
package stream_pkg;

  localparam int ACT_DATA_WIDTH = 8;
  // Lanes per 32b word
  localparam int N_DIM_ARRAY    = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_PAD  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/stream_pack_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester at or after rr_ptr,
// scanning upward with wrap-around; one-hot result.
module rr_pick
  import stream_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int PTR_W = ptr_width(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] rr_ptr,
  output logic [N_REQ-1:0] pick
);

  logic             w_found;
  int               w_idx;
  logic [N_REQ-1:0] w_hit;

  // Rotating priority scan over all offsets from rr_ptr
  always_comb begin
    pick    = '0;
    w_found = 1'b0;
    w_idx   = 0;
    w_hit   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      w_idx = (int'(rr_ptr) + i) % N_REQ;
      for (int j = 0; j < N_REQ; j++) begin
        w_hit[j] = (j == w_idx) && req[j] && !w_found;
      end
      pick    = pick | w_hit;
      w_found = w_found | (|w_hit);
    end
  end

endmodule

// File: rtl/stream_pack_arbiter.sv
// Round-robin arbiter feeding a shared 32b-to-64b packer; odd-length bursts
// get one zero PAD word so the packer stays pair-aligned.
module stream_pack_arbiter #(
  parameter int N_REQ          = 2,
  parameter int ACT_DATA_WIDTH = stream_pkg::ACT_DATA_WIDTH,
  parameter int LEN_WIDTH      = 16
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [N_REQ-1:0]                req,
  input  logic [N_REQ*LEN_WIDTH-1:0]      req_len,
  input  logic [N_REQ-1:0]                req_valid,
  input  logic [N_REQ*4*ACT_DATA_WIDTH-1:0] req_word,
  input  logic [N_REQ*32-1:0]             req_addr,
  output logic [N_REQ-1:0]                gnt,
  output logic [N_REQ-1:0]                req_ready,
  output logic [N_REQ-1:0]                done,
  output logic                            pack_en,
  output logic [4*ACT_DATA_WIDTH-1:0]     pack_word,
  output logic [31:0]                     pack_addr,
  output logic                            busy
);
  import stream_pkg::*;

  localparam int WORD_W = N_DIM_ARRAY * ACT_DATA_WIDTH;
  localparam int PTR_W  = ptr_width(N_REQ);

  state_e               r_state;
  state_e               w_state_nxt;
  logic [N_REQ-1:0]     r_gnt;
  logic [PTR_W-1:0]     r_gnt_idx;
  logic [PTR_W-1:0]     r_rr_ptr;
  logic [LEN_WIDTH-1:0] r_cnt;
  logic                 r_parity;
  logic [31:0]          r_last_addr;

  logic [N_REQ-1:0]     w_pick;
  logic [PTR_W-1:0]     w_pick_idx;
  logic [LEN_WIDTH-1:0] w_pick_len;
  logic                 w_sel_valid;
  logic [WORD_W-1:0]    w_sel_word;
  logic [31:0]          w_sel_addr;
  logic                 w_accept;

  rr_pick #(
    .N_REQ (N_REQ),
    .PTR_W (PTR_W)
  ) u_rr_pick (
    .req    (req),
    .rr_ptr (r_rr_ptr),
    .pick   (w_pick)
  );

  // One-hot AND-OR muxes: picked length for IDLE, granted lane for XFER
  always_comb begin
    w_pick_idx = '0;
    w_pick_len = '0;
    w_sel_word = '0;
    w_sel_addr = '0;
    for (int i = 0; i < N_REQ; i++) begin
      w_pick_idx = w_pick[i] ? PTR_W'(i) : w_pick_idx;
      w_pick_len = w_pick_len | (req_len[i*LEN_WIDTH +: LEN_WIDTH] & {LEN_WIDTH{w_pick[i]}});
      w_sel_word = w_sel_word | (req_word[i*WORD_W +: WORD_W] & {WORD_W{r_gnt[i]}});
      w_sel_addr = w_sel_addr | (req_addr[i*32 +: 32] & {32{r_gnt[i]}});
    end
  end

  assign w_sel_valid = |(req_valid & r_gnt);
  assign gnt         = r_gnt;
  assign busy        = (r_state != ST_IDLE);

  // Next-state and packer/handshake outputs
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    req_ready   = '0;
    done        = '0;
    pack_en     = 1'b0;
    pack_word   = '0;
    pack_addr   = '0;
    case (r_state)
      ST_IDLE: begin
        if (|req) begin
          w_state_nxt = (w_pick_len == '0) ? ST_DONE : ST_XFER;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_XFER: begin
        req_ready = r_gnt;
        pack_en   = w_sel_valid;
        pack_word = w_sel_word;
        pack_addr = w_sel_addr;
        w_accept  = w_sel_valid;
        // Parity still holds the pre-toggle value here: 0 means odd length
        if (w_accept && (r_cnt == LEN_WIDTH'(1))) begin
          w_state_nxt = r_parity ? ST_DONE : ST_PAD;
        end else begin
          w_state_nxt = ST_XFER;
        end
      end
      ST_PAD: begin
        pack_en     = 1'b1;
        pack_addr   = r_last_addr + 32'd4;
        w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        done        = r_gnt;
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State, grant, word counter, parity and round-robin pointer
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_gnt       <= '0;
      r_gnt_idx   <= '0;
      r_rr_ptr    <= '0;
      r_cnt       <= '0;
      r_parity    <= 1'b0;
      r_last_addr <= 32'd0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        ST_IDLE: begin
          if (|req) begin
            r_gnt     <= w_pick;
            r_gnt_idx <= w_pick_idx;
            r_cnt     <= w_pick_len;
          end
        end
        ST_XFER: begin
          if (w_accept) begin
            r_cnt       <= r_cnt - LEN_WIDTH'(1);
            r_parity    <= ~r_parity;
            r_last_addr <= w_sel_addr;
          end
        end
        ST_DONE: begin
          r_gnt    <= '0;
          r_rr_ptr <= PTR_W'((int'(r_gnt_idx) + 1) % N_REQ);
          r_parity <= 1'b0;
          r_cnt    <= '0;
        end
        default: begin
          r_cnt <= r_cnt;
        end
      endcase
    end
  end

endmodule
